// File: rtl/dram_line_sequencer.sv
// Cache-line front end for the DRAM user interface. Writebacks leave as two 128-bit
// write beats, refills as one read command; read beats are reassembled into tagged lines.
package iu_clk_pkg;
  typedef struct packed {
    logic clk;
  } iu_clk_type;
endpackage

// state | meaning
// IDLE  | issue a held read, or beat 0 of a held write
// WR1   | beat 0 sent; beat 1 must follow before anything else
module dram_line_sequencer
  import iu_clk_pkg::*;
#(
  parameter int TAGW      = 5,
  parameter int RDQ_DEPTH = 4
) (
  input  iu_clk_type         gclk,
  input  logic               rst,
  input  logic               line_req_val,
  output logic               line_req_rdy,
  input  logic               line_req_rw,
  input  logic [25:0]        line_req_addr,
  input  logic [255:0]       line_req_data,
  input  logic [TAGW-1:0]    line_req_tag,
  output logic               line_resp_val,
  output logic [255:0]       line_resp_data,
  output logic [TAGW-1:0]    line_resp_tag,
  output logic               mem_req_val,
  input  logic               mem_req_rdy,
  output logic               mem_req_rw,
  output logic [25:0]        mem_req_addr,
  output logic [127:0]       mem_req_data,
  input  logic               mem_resp_val,
  input  logic [127:0]       mem_resp_data,
  output logic               err_orphan
);

  localparam int PW = $clog2(RDQ_DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(RDQ_DEPTH);

  typedef enum logic {S_IDLE, S_WR1} state_t;

  state_t            r_state;
  logic              r_full;
  logic              r_rw;
  logic [25:0]       r_addr;
  logic [255:0]      r_data;
  logic [TAGW-1:0]   r_tag;

  logic [TAGW-1:0]   r_tagq [RDQ_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PW:0]       r_cnt;

  logic              r_beat;
  logic [127:0]      r_lo;
  logic              r_resp_val;
  logic [255:0]      r_resp_data;
  logic [TAGW-1:0]   r_resp_tag;
  logic              r_orphan;

  logic w_fifo_full, w_fifo_empty;
  logic w_rd_go, w_wr0_go, w_wr1_go;
  logic w_take, w_free, w_push, w_pop;

  assign w_fifo_full  = (r_cnt == CNT_FULL);
  assign w_fifo_empty = (r_cnt == '0);

  // Beats are only presented when the controller is ready, so every beat shown is taken.
  assign w_rd_go  = (r_state == S_IDLE) & r_full & ~r_rw & ~w_fifo_full & mem_req_rdy;
  assign w_wr0_go = (r_state == S_IDLE) & r_full & r_rw & mem_req_rdy;
  assign w_wr1_go = (r_state == S_WR1) & mem_req_rdy;

  assign w_take = line_req_val & ~r_full;
  assign w_free = w_rd_go | w_wr1_go;
  assign w_push = w_rd_go;
  assign w_pop  = mem_resp_val & r_beat;

  assign line_req_rdy   = ~r_full;
  assign mem_req_val    = w_rd_go | w_wr0_go | w_wr1_go;
  assign mem_req_rw     = (r_state == S_WR1) | (r_full & r_rw);
  assign mem_req_addr   = r_addr;
  assign mem_req_data   = (r_state == S_WR1) ? r_data[255:128] : r_data[127:0];
  assign line_resp_val  = r_resp_val;
  assign line_resp_data = r_resp_data;
  assign line_resp_tag  = r_resp_tag;
  assign err_orphan     = r_orphan;

  always_ff @(posedge gclk.clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_full      <= 1'b0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_tag       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_beat      <= 1'b0;
      r_lo        <= '0;
      r_resp_val  <= 1'b0;
      r_resp_data <= '0;
      r_resp_tag  <= '0;
      r_orphan    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_wr0_go) r_state <= S_WR1;
        S_WR1:   if (w_wr1_go) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_take) begin
        r_full <= 1'b1;
        r_rw   <= line_req_rw;
        r_addr <= line_req_addr;
        r_data <= line_req_data;
        r_tag  <= line_req_tag;
      end else if (w_free) begin
        r_full <= 1'b0;
      end

      if (w_push) begin
        r_tagq[r_wptr] <= r_tag;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase

      // A first beat with nothing outstanding is dropped and flagged.
      r_resp_val <= w_pop;
      if (mem_resp_val) begin
        if (r_beat) begin
          r_resp_data <= {mem_resp_data, r_lo};
          r_resp_tag  <= r_tagq[r_rptr];
          r_beat      <= 1'b0;
        end else if (!w_fifo_empty) begin
          r_lo   <= mem_resp_data;
          r_beat <= 1'b1;
        end else begin
          r_orphan <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_line_sequencer.sv
// Directed bench for dram_line_sequencer: refill, writeback, back-pressure,
// read-queue full, orphan beats and reset in the middle of a write.
module tb_dram_line_sequencer;
  import iu_clk_pkg::*;

  localparam int TAGW = 5;

  logic            clk;
  iu_clk_type      gclk;
  logic            rst;
  logic            line_req_val, line_req_rdy, line_req_rw;
  logic [25:0]     line_req_addr;
  logic [255:0]    line_req_data;
  logic [TAGW-1:0] line_req_tag;
  logic            line_resp_val;
  logic [255:0]    line_resp_data;
  logic [TAGW-1:0] line_resp_tag;
  logic            mem_req_val, mem_req_rdy, mem_req_rw;
  logic [25:0]     mem_req_addr;
  logic [127:0]    mem_req_data;
  logic            mem_resp_val;
  logic [127:0]    mem_resp_data;
  logic            err_orphan;

  assign gclk.clk = clk;

  dram_line_sequencer #(.TAGW(TAGW), .RDQ_DEPTH(4)) dut (
    .gclk(gclk), .rst(rst),
    .line_req_val(line_req_val), .line_req_rdy(line_req_rdy), .line_req_rw(line_req_rw),
    .line_req_addr(line_req_addr), .line_req_data(line_req_data), .line_req_tag(line_req_tag),
    .line_resp_val(line_resp_val), .line_resp_data(line_resp_data), .line_resp_tag(line_resp_tag),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data), .err_orphan(err_orphan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            mq_rw   [$];
  logic [25:0]     mq_addr [$];
  logic [127:0]    mq_data [$];
  int              mq_cyc  [$];
  logic [255:0]    rq_data [$];
  logic [TAGW-1:0] rq_tag  [$];
  int              rq_cyc  [$];
  int              n_rdy_low = 0;

  // Mid-cycle monitor: inputs are driven right after negedge, so everything is settled here.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (mem_req_val) begin
        mq_rw.push_back(mem_req_rw);
        mq_addr.push_back(mem_req_addr);
        mq_data.push_back(mem_req_data);
        mq_cyc.push_back(cyc);
        n_cmp++;
        if (mem_req_rdy !== 1'b1) begin
          n_bad++;
          $display("FAIL val_without_rdy: mem_req_val=1 while mem_req_rdy=%b, required 1", mem_req_rdy);
        end
      end
      if (line_resp_val === 1'b1) begin
        rq_data.push_back(line_resp_data);
        rq_tag.push_back(line_resp_tag);
        rq_cyc.push_back(cyc);
      end
      if (line_req_rdy !== 1'b1) n_rdy_low++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_logs();
    mq_rw.delete(); mq_addr.delete(); mq_data.delete(); mq_cyc.delete();
    rq_data.delete(); rq_tag.delete(); rq_cyc.delete();
    n_rdy_low = 0;
  endtask

  task automatic send_req(input logic rw, input logic [25:0] addr,
                          input logic [255:0] data, input logic [TAGW-1:0] tag);
    int k;
    k = 0;
    while (line_req_rdy !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    n_cmp++;
    if (line_req_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL req_accept_timeout: line_req_rdy=%b, required 1", line_req_rdy);
    end
    line_req_val = 1'b1; line_req_rw = rw; line_req_addr = addr;
    line_req_data = data; line_req_tag = tag;
    tick();
    line_req_val = 1'b0;
  endtask

  task automatic beat(input logic [127:0] d);
    mem_resp_val = 1'b1;
    mem_resp_data = d;
    tick();
    mem_resp_val = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; line_req_val = 1'b0; line_req_rw = 1'b0; line_req_addr = '0;
    line_req_data = '0; line_req_tag = '0; mem_req_rdy = 1'b0;
    mem_resp_val = 1'b0; mem_resp_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    mem_req_rdy = 1'b1;
    #1;
    n_cmp++;
    if ({line_req_rdy, mem_req_val, mem_req_rw, err_orphan, line_resp_val} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_ctrl: {rdy,mval,mrw,orph,rval}=%b, required 10000",
               {line_req_rdy, mem_req_val, mem_req_rw, err_orphan, line_resp_val});
    end
    n_cmp++;
    if ({mem_req_addr, mem_req_data, line_resp_data, line_resp_tag} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: addr=%h mdata=%h rtag=%h, required all zero",
               mem_req_addr, mem_req_data, line_resp_tag);
    end
    tick();
  endtask

  task automatic test_single_refill();
    logic [127:0] a, b;
    a = 128'h0123456789ABCDEF_0011223344556677;
    b = 128'hFEDCBA9876543210_8899AABBCCDDEEFF;
    clear_logs();
    mem_req_rdy = 1'b1;
    send_req(1'b0, 26'h0000123, '0, 5'd3);
    #1;
    n_cmp++;
    if ({mem_req_val, mem_req_rw, mem_req_addr} !== {1'b1, 1'b0, 26'h0000123}) begin
      n_bad++;
      $display("FAIL refill_issue: val=%b rw=%b addr=%h, required 1 0 0000123",
               mem_req_val, mem_req_rw, mem_req_addr);
    end
    repeat (3) tick();
    n_cmp++;
    if (mq_cyc.size() != 1) begin
      n_bad++;
      $display("FAIL refill_cmd_count: %0d commands, required 1", mq_cyc.size());
    end
    beat(a);
    tick();
    beat(b);
    repeat (3) tick();
    n_cmp++;
    if (rq_cyc.size() != 1) begin
      n_bad++;
      $display("FAIL refill_resp_count: %0d response cycles, required 1", rq_cyc.size());
    end else begin
      n_cmp++;
      if (rq_data[0] !== {b, a} || rq_tag[0] !== 5'd3) begin
        n_bad++;
        $display("FAIL refill_resp: tag=%0d data=%h, required tag 3 data %h", rq_tag[0], rq_data[0], {b, a});
      end
    end
  endtask

  task automatic test_writeback();
    logic [255:0] d;
    d = {{32{4'hF}}, {32{4'h1}}};
    clear_logs();
    mem_req_rdy = 1'b1;
    send_req(1'b1, 26'h01F00A5, d, '0);
    repeat (4) tick();
    n_cmp++;
    if (mq_cyc.size() != 2) begin
      n_bad++;
      $display("FAIL wb_beat_count: %0d beats, required 2", mq_cyc.size());
    end else begin
      n_cmp++;
      if ({mq_rw[0], mq_addr[0], mq_data[0]} !== {1'b1, 26'h01F00A5, d[127:0]}) begin
        n_bad++;
        $display("FAIL wb_beat0: rw=%b addr=%h data=%h, required 1 01f00a5 %h",
                 mq_rw[0], mq_addr[0], mq_data[0], d[127:0]);
      end
      n_cmp++;
      if ({mq_rw[1], mq_addr[1], mq_data[1]} !== {1'b1, 26'h01F00A5, d[255:128]} ||
          mq_cyc[1] != mq_cyc[0] + 1) begin
        n_bad++;
        $display("FAIL wb_beat1: rw=%b addr=%h data=%h gap=%0d, required 1 01f00a5 %h gap 1",
                 mq_rw[1], mq_addr[1], mq_data[1], mq_cyc[1] - mq_cyc[0], d[255:128]);
      end
    end
    n_cmp++;
    if (n_rdy_low != 2) begin
      n_bad++;
      $display("FAIL wb_rdy_low: line_req_rdy low %0d cycles, required 2", n_rdy_low);
    end
  endtask

  task automatic test_wr_backpressure();
    logic [255:0] d;
    logic [127:0] c, e;
    d = {128'hCAFE_0000_0000_0000_0000_0000_0000_0002, 128'hBEEF_0000_0000_0000_0000_0000_0000_0001};
    c = 128'h5555; e = 128'h6666;
    clear_logs();
    mem_req_rdy = 1'b1;
    send_req(1'b1, 26'h000ABCD, d, '0);
    line_req_val = 1'b1; line_req_rw = 1'b0; line_req_addr = 26'h000BEEF;
    line_req_data = '0; line_req_tag = 5'd7;
    tick();
    mem_req_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (mem_req_val !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_val: stall cycle %0d mem_req_val=%b, required 0", i, mem_req_val);
      end
      tick();
    end
    mem_req_rdy = 1'b1;
    #1;
    n_cmp++;
    if ({mem_req_val, mem_req_rw, mem_req_data} !== {1'b1, 1'b1, d[255:128]}) begin
      n_bad++;
      $display("FAIL stall_beat1: val=%b rw=%b data=%h, required 1 1 %h",
               mem_req_val, mem_req_rw, mem_req_data, d[255:128]);
    end
    tick();
    tick();
    line_req_val = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (mq_cyc.size() != 3) begin
      n_bad++;
      $display("FAIL stall_cmd_count: %0d commands, required 3", mq_cyc.size());
    end else begin
      n_cmp++;
      if (mq_rw[0] !== 1'b1 || mq_rw[1] !== 1'b1 || mq_data[1] !== d[255:128] ||
          mq_cyc[1] != mq_cyc[0] + 6) begin
        n_bad++;
        $display("FAIL stall_order: rw0=%b rw1=%b data1=%h gap=%0d, required 1 1 %h gap 6",
                 mq_rw[0], mq_rw[1], mq_data[1], mq_cyc[1] - mq_cyc[0], d[255:128]);
      end
      n_cmp++;
      if ({mq_rw[2], mq_addr[2]} !== {1'b0, 26'h000BEEF}) begin
        n_bad++;
        $display("FAIL stall_read_after: rw=%b addr=%h, required 0 000beef", mq_rw[2], mq_addr[2]);
      end
    end
    beat(c);
    beat(e);
    repeat (3) tick();
    n_cmp++;
    if (rq_cyc.size() != 1 || rq_tag[0] !== 5'd7 || rq_data[0] !== {e, c}) begin
      n_bad++;
      $display("FAIL stall_read_resp: count=%0d tag=%0d, required count 1 tag 7 data %h",
               rq_cyc.size(), rq_tag[0], {e, c});
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] lo, hi;
    clear_logs();
    mem_req_rdy = 1'b1;
    for (int i = 1; i <= 5; i++) send_req(1'b0, 26'h100 + 26'(i), '0, TAGW'(i));
    repeat (5) tick();
    #1;
    n_cmp++;
    if (mq_cyc.size() != 4 || line_req_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_full: %0d reads issued rdy=%b, required 4 reads rdy 0", mq_cyc.size(), line_req_rdy);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (mq_addr[i] !== 26'h101 + 26'(i)) begin
          n_bad++;
          $display("FAIL b2b_addr: read %0d addr=%h, required %h", i, mq_addr[i], 26'h101 + 26'(i));
        end
      end
    end
    beat(128'hA001);
    beat(128'hB001);
    repeat (3) tick();
    n_cmp++;
    if (mq_cyc.size() != 5 || rq_cyc.size() != 1) begin
      n_bad++;
      $display("FAIL b2b_fifth: reads=%0d lines=%0d, required 5 reads 1 line", mq_cyc.size(), rq_cyc.size());
    end else begin
      n_cmp++;
      if (mq_cyc[4] < rq_cyc[0] || mq_addr[4] !== 26'h105) begin
        n_bad++;
        $display("FAIL b2b_fifth_timing: read5 cycle %0d addr %h, first line cycle %0d, required read5 not earlier, addr 105",
                 mq_cyc[4], mq_addr[4], rq_cyc[0]);
      end
    end
    for (int i = 2; i <= 5; i++) begin
      lo = 128'hA000 + 128'(i);
      hi = 128'hB000 + 128'(i);
      beat(lo);
      beat(hi);
    end
    repeat (3) tick();
    n_cmp++;
    if (rq_cyc.size() != 5) begin
      n_bad++;
      $display("FAIL b2b_line_count: %0d lines, required 5", rq_cyc.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        lo = 128'hA001 + 128'(i);
        hi = 128'hB001 + 128'(i);
        n_cmp++;
        if (rq_tag[i] !== TAGW'(i + 1) || rq_data[i] !== {hi, lo}) begin
          n_bad++;
          $display("FAIL b2b_line: line %0d tag=%0d data=%h, required tag %0d data %h",
                   i, rq_tag[i], rq_data[i], i + 1, {hi, lo});
        end
      end
    end
  endtask

  task automatic test_orphan();
    clear_logs();
    beat(128'h0DD1);
    n_cmp++;
    if (err_orphan !== 1'b1) begin
      n_bad++;
      $display("FAIL orphan_set: err_orphan=%b, required 1", err_orphan);
    end
    repeat (5) tick();
    beat(128'h0DD2);
    repeat (3) tick();
    n_cmp++;
    if (err_orphan !== 1'b1 || rq_cyc.size() != 0) begin
      n_bad++;
      $display("FAIL orphan_sticky: err_orphan=%b lines=%0d, required 1 and 0", err_orphan, rq_cyc.size());
    end
  endtask

  task automatic test_reset_mid_write();
    clear_logs();
    mem_req_rdy = 1'b1;
    send_req(1'b0, 26'h0000333, '0, 5'd9);
    tick();
    send_req(1'b1, 26'h0000444, {128'h7777, 128'h8888}, '0);
    tick();
    mem_req_rdy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_req_rdy = 1'b1;
    #1;
    n_cmp++;
    if (line_req_rdy !== 1'b1 || err_orphan !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_state: line_req_rdy=%b err_orphan=%b, required 1 0", line_req_rdy, err_orphan);
    end
    repeat (5) tick();
    n_cmp++;
    if (mq_cyc.size() != 2) begin
      n_bad++;
      $display("FAIL rst_mid_beats: %0d commands, required 2 (read, beat 0)", mq_cyc.size());
    end
    beat(128'h0DD3);
    repeat (2) tick();
    n_cmp++;
    if (err_orphan !== 1'b1 || rq_cyc.size() != 0) begin
      n_bad++;
      $display("FAIL rst_mid_fifo: err_orphan=%b lines=%0d, required 1 and 0", err_orphan, rq_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_refill();
    test_writeback();
    test_wr_backpressure();
    test_back_to_back();
    test_orphan();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
